// File: rtl/jelly2_axi4s_video_regularizer.sv
// rtl/jelly2_axi4s_video_regularizer.sv - forces every AXI4-Stream video frame to exactly param_width x param_height
module jelly2_axi4s_video_regularizer #(
  parameter int TUSER_WIDTH   = 1,
  parameter int TDATA_WIDTH   = 8,
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 9,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     aresetn,
  input  logic                     aclk,
  input  logic                     aclken,
  input  logic [X_WIDTH-1:0]       param_width,
  input  logic [Y_WIDTH-1:0]       param_height,
  input  logic [TDATA_WIDTH-1:0]   param_fill,
  input  logic [TIMEOUT_WIDTH-1:0] param_timeout,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TDATA_WIDTH-1:0]   s_axi4s_tdata,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic                     busy,
  output logic                     fix_pulse
);

  typedef enum logic [2:0] {ST_SYNC, ST_PASS, ST_PAD_LINE, ST_SKIP, ST_PAD_FRAME} state_t;

  state_t                   state, state_next;
  logic [X_WIDTH-1:0]       x, x_next, x_step, width, width_next;
  logic [Y_WIDTH-1:0]       y, y_next, y_step, height, height_next;
  logic [TIMEOUT_WIDTH-1:0] tcnt, tcnt_next;
  logic                     fix_next, load, ld_tlast;
  logic [TUSER_WIDTH-1:0]   ld_tuser;
  logic [TDATA_WIDTH-1:0]   ld_tdata;
  logic                     adv, x_end, y_end, origin, s_sof, accept;

  assign adv    = aclken && (!m_axi4s_tvalid || m_axi4s_tready);
  assign x_end  = (x == width - X_WIDTH'(1));
  assign y_end  = (y == height - Y_WIDTH'(1));
  assign origin = (x == '0) && (y == '0);
  assign s_sof  = s_axi4s_tuser[0];
  assign accept = s_axi4s_tvalid && s_axi4s_tready;
  assign busy   = (state != ST_SYNC);

  // raster position after emitting the beat at (x,y); wraps to (0,0) at frame end
  assign x_step = x_end ? '0 : x + X_WIDTH'(1);
  assign y_step = x_end ? (y_end ? '0 : y + Y_WIDTH'(1)) : y;

  always_comb begin
    state_next     = state;
    x_next         = x;
    y_next         = y;
    width_next     = width;
    height_next    = height;
    tcnt_next      = tcnt;
    fix_next       = 1'b0;
    load           = 1'b0;
    s_axi4s_tready = 1'b0;
    ld_tuser       = TUSER_WIDTH'(origin);
    ld_tlast       = x_end;
    ld_tdata       = param_fill;
    case (state)
      ST_SYNC: begin
        // a frame-start beat is only taken when the output register can hold it
        s_axi4s_tready = aclken && (adv || !s_sof);
        tcnt_next      = '0;
        if (accept && s_sof) begin
          load        = 1'b1;
          width_next  = param_width;
          height_next = param_height;
          ld_tuser    = s_axi4s_tuser | TUSER_WIDTH'(1);
          ld_tlast    = (param_width == X_WIDTH'(1));
          ld_tdata    = s_axi4s_tdata;
          x_next      = X_WIDTH'(1);
          y_next      = '0;
          state_next  = ST_PASS;
          if (param_width == X_WIDTH'(1)) begin
            x_next = '0;
            y_next = Y_WIDTH'(1);
            if (param_height == Y_WIDTH'(1)) begin
              y_next     = '0;
              state_next = ST_SYNC;
            end else if (!s_axi4s_tlast) begin
              state_next = ST_SKIP;
              fix_next   = 1'b1;
            end
          end else if (s_axi4s_tlast) begin
            state_next = ST_PAD_LINE;
            fix_next   = 1'b1;
          end
        end
      end
      ST_PASS: begin
        s_axi4s_tready = adv && !(s_sof && !origin);
        if (accept) begin
          load      = 1'b1;
          ld_tuser  = (s_axi4s_tuser & ~TUSER_WIDTH'(1)) | TUSER_WIDTH'(origin);
          ld_tdata  = s_axi4s_tdata;
          tcnt_next = '0;
          x_next    = x_step;
          y_next    = y_step;
          if (x_end && y_end) begin
            state_next = ST_SYNC;
          end else if (x_end && !s_axi4s_tlast) begin
            state_next = ST_SKIP;
            fix_next   = 1'b1;
          end else if (!x_end && s_axi4s_tlast) begin
            state_next = ST_PAD_LINE;
            fix_next   = 1'b1;
          end
        end else if (aclken && s_axi4s_tvalid && s_sof && !origin) begin
          state_next = ST_PAD_FRAME;
          fix_next   = 1'b1;
          tcnt_next  = '0;
        end else if (aclken) begin
          tcnt_next = tcnt + TIMEOUT_WIDTH'(1);
          if (param_timeout != '0 && tcnt_next == param_timeout) begin
            state_next = ST_PAD_FRAME;
            fix_next   = 1'b1;
            tcnt_next  = '0;
          end
        end
      end
      ST_PAD_LINE: begin
        if (adv) begin
          load   = 1'b1;
          x_next = x_step;
          y_next = y_step;
          if (x_end) state_next = y_end ? ST_SYNC : ST_PASS;
        end
      end
      ST_SKIP: begin
        // the next frame start must stay on the bus for SYNC to pick up
        s_axi4s_tready = aclken && !s_sof;
        if (aclken && s_axi4s_tvalid) begin
          if (s_sof) begin
            state_next = ST_PAD_FRAME;
            fix_next   = 1'b1;
          end else if (s_axi4s_tlast) begin
            state_next = ST_PASS;
          end
        end
      end
      ST_PAD_FRAME: begin
        if (adv) begin
          load   = 1'b1;
          x_next = x_step;
          y_next = y_step;
          if (x_end && y_end) state_next = ST_SYNC;
        end
      end
      default: state_next = ST_SYNC;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_SYNC;
    else          state <= state_next;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      x              <= '0;
      y              <= '0;
      width          <= '0;
      height         <= '0;
      tcnt           <= '0;
      fix_pulse      <= 1'b0;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser  <= '0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tdata  <= '0;
    end else begin
      x         <= x_next;
      y         <= y_next;
      width     <= width_next;
      height    <= height_next;
      tcnt      <= tcnt_next;
      fix_pulse <= fix_next;
      if (load) begin
        m_axi4s_tvalid <= 1'b1;
        m_axi4s_tuser  <= ld_tuser;
        m_axi4s_tlast  <= ld_tlast;
        m_axi4s_tdata  <= ld_tdata;
      end else if (aclken && m_axi4s_tready) begin
        m_axi4s_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jelly2_axi4s_video_regularizer.sv
// tb/tb_jelly2_axi4s_video_regularizer.sv - randomized bench checked against a frame-level reference model
`timescale 1ns/1ps
module tb_jelly2_axi4s_video_regularizer;
  localparam int TUW = 2;
  localparam int TDW = 8;
  localparam int XW  = 10;
  localparam int YW  = 9;
  localparam int TOW = 16;

  logic           aresetn = 1'b0;
  logic           aclk    = 1'b0;
  logic           aclken  = 1'b0;
  logic [XW-1:0]  param_width   = 10'd8;
  logic [YW-1:0]  param_height  = 9'd4;
  logic [TDW-1:0] param_fill    = 8'hAA;
  logic [TOW-1:0] param_timeout = '0;
  logic [TUW-1:0] s_axi4s_tuser = '0;
  logic           s_axi4s_tlast = 1'b0;
  logic [TDW-1:0] s_axi4s_tdata = '0;
  logic           s_axi4s_tvalid = 1'b0;
  logic           s_axi4s_tready;
  logic [TUW-1:0] m_axi4s_tuser;
  logic           m_axi4s_tlast;
  logic [TDW-1:0] m_axi4s_tdata;
  logic           m_axi4s_tvalid;
  logic           m_axi4s_tready = 1'b0;
  logic           busy;
  logic           fix_pulse;

  always #5 aclk = ~aclk;

  jelly2_axi4s_video_regularizer #(
    .TUSER_WIDTH(TUW), .TDATA_WIDTH(TDW), .X_WIDTH(XW), .Y_WIDTH(YW), .TIMEOUT_WIDTH(TOW)
  ) dut (
    .aresetn(aresetn), .aclk(aclk), .aclken(aclken),
    .param_width(param_width), .param_height(param_height),
    .param_fill(param_fill), .param_timeout(param_timeout),
    .s_axi4s_tuser(s_axi4s_tuser), .s_axi4s_tlast(s_axi4s_tlast),
    .s_axi4s_tdata(s_axi4s_tdata), .s_axi4s_tvalid(s_axi4s_tvalid),
    .s_axi4s_tready(s_axi4s_tready),
    .m_axi4s_tuser(m_axi4s_tuser), .m_axi4s_tlast(m_axi4s_tlast),
    .m_axi4s_tdata(m_axi4s_tdata), .m_axi4s_tvalid(m_axi4s_tvalid),
    .m_axi4s_tready(m_axi4s_tready),
    .busy(busy), .fix_pulse(fix_pulse)
  );

  typedef struct packed {
    logic [TUW-1:0] user;
    logic           last;
    logic [TDW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t act_q[$];
  beat_t act_log[$];
  int checks = 0, errors = 0, beat_no = 0;
  int fix_exp = 0, fix_act = 0;
  int en_rand = 0, rdy_rand = 0, rdy_busy = 30, bubble = 20;
  // reference model: 0 waiting for frame start, 1 passing, 2 discarding rest of a long line
  int m_st = 0, m_x = 0, m_y = 0, m_w = 1, m_h = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void m_emit(input logic [TDW-1:0] d, input logic hi);
    beat_t b;
    b.data = d;
    b.user = {hi, (m_x == 0 && m_y == 0)};
    b.last = (m_x == m_w - 1);
    exp_q.push_back(b);
    if (m_x == m_w - 1) begin m_x = 0; m_y++; end
    else m_x++;
  endfunction

  function automatic void m_close();
    if (m_y == m_h) begin m_st = 0; m_x = 0; m_y = 0; end
  endfunction

  function automatic void m_pad_frame();
    while (m_y < m_h) m_emit(param_fill, 1'b0);
    m_close();
  endfunction

  function automatic void m_pass(input logic [TDW-1:0] d, input logic [TUW-1:0] u, input logic l);
    bit line_end;
    line_end = (m_x == m_w - 1);
    m_emit(d, u[1]);
    if (m_y == m_h) m_close();
    else if (line_end && !l) begin fix_exp++; m_st = 2; end
    else if (!line_end && l) begin
      fix_exp++;
      do m_emit(param_fill, 1'b0); while (m_x != 0);
      m_close();
    end
  endfunction

  function automatic void m_beat(input logic [TDW-1:0] d, input logic [TUW-1:0] u, input logic l);
    bit again;
    do begin
      again = 0;
      case (m_st)
        0: if (u[0]) begin
             m_w = int'(param_width); m_h = int'(param_height);
             m_x = 0; m_y = 0; m_st = 1;
             m_pass(d, u, l);
           end
        1: if (u[0] && !(m_x == 0 && m_y == 0)) begin fix_exp++; m_pad_frame(); again = 1; end
           else m_pass(d, u, l);
        default: if (u[0]) begin fix_exp++; m_pad_frame(); again = 1; end
                 else if (l) m_st = 1;
      endcase
    end while (again);
  endfunction

  function automatic void m_timeout();
    if (m_st == 1) begin fix_exp++; m_pad_frame(); end
  endfunction

  always @(negedge aclk) begin : monitor
    beat_t a, e;
    if (aresetn) begin
      if (fix_pulse) fix_act++;
      if (s_axi4s_tvalid && s_axi4s_tready) m_beat(s_axi4s_tdata, s_axi4s_tuser, s_axi4s_tlast);
      if (m_axi4s_tvalid && m_axi4s_tready && aclken) begin
        a.user = m_axi4s_tuser; a.last = m_axi4s_tlast; a.data = m_axi4s_tdata;
        act_q.push_back(a);
        act_log.push_back(a);
      end
      while (exp_q.size() > 0 && act_q.size() > 0) begin
        e = exp_q.pop_front();
        a = act_q.pop_front();
        chk($sformatf("beat%0d", beat_no), 32'(a), 32'(e));
        beat_no++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge aclk); #1;
      if (en_rand != 0)  aclken = ($urandom_range(9) != 0);
      if (rdy_rand != 0) m_axi4s_tready = ($urandom_range(99) >= rdy_busy);
    end
  end

  task automatic send(input logic [TDW-1:0] d, input logic [TUW-1:0] u, input logic l);
    int n = 0;
    while ($urandom_range(99) < bubble) begin s_axi4s_tvalid = 1'b0; @(posedge aclk); #1; end
    s_axi4s_tdata = d; s_axi4s_tuser = u; s_axi4s_tlast = l; s_axi4s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_axi4s_tready && n < 2000) begin n++; @(negedge aclk); end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL send_stall: tready low for %0d cycles required within 2000", n);
    end
    @(posedge aclk); #1;
    s_axi4s_tvalid = 1'b0;
  endtask

  task automatic send_line(input int n, input bit sof);
    for (int i = 0; i < n; i++)
      send(TDW'($urandom), {1'($urandom_range(1)), 1'(sof && i == 0)}, (i == n - 1));
  endtask

  task automatic send_frame(input int l0, input int l1, input int l2, input int l3);
    if (l0 > 0) send_line(l0, 1'b1);
    if (l1 > 0) send_line(l1, 1'b0);
    if (l2 > 0) send_line(l2, 1'b0);
    if (l3 > 0) send_line(l3, 1'b0);
  endtask

  task automatic send_clean();
    for (int l = 0; l < int'(param_height); l++) send_line(int'(param_width), (l == 0));
  endtask

  task automatic start_test();
    act_log.delete();
    fix_exp = 0;
    fix_act = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || act_q.size() != 0 || busy) && n < 3000) begin
      @(posedge aclk); #1; n++;
    end
    repeat (10) begin @(posedge aclk); #1; end
    chk({name, "_pending"}, 32'(exp_q.size() + act_q.size()), 32'd0);
    chk({name, "_fix"}, 32'(fix_act), 32'(fix_exp));
  endtask

  function automatic beat_t logb(input int i);
    beat_t b;
    b = 'x;
    if (i < act_log.size()) b = act_log[i];
    return b;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int sofs;
    repeat (5) @(posedge aclk);
    #1;
    chk("rst_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    chk("rst_tuser",  32'(m_axi4s_tuser),  32'd0);
    chk("rst_tlast",  32'(m_axi4s_tlast),  32'd0);
    chk("rst_tdata",  32'(m_axi4s_tdata),  32'd0);
    chk("rst_busy",   32'(busy),           32'd0);
    chk("rst_fix",    32'(fix_pulse),      32'd0);
    aresetn = 1'b1;
    en_rand = 1; rdy_rand = 1;
    @(posedge aclk); #1;

    // clean frames
    start_test();
    repeat (3) send_clean();
    drain("clean");
    chk("clean_fix_lit", 32'(fix_act), 32'd0);
    chk("clean_count", 32'(act_log.size()), 32'd96);
    sofs = 0;
    foreach (act_log[i]) if (act_log[i].user[0]) sofs++;
    chk("clean_sof", 32'(sofs), 32'd3);

    // short line 1
    start_test();
    send_frame(8, 5, 8, 8);
    drain("short");
    chk("short_count", 32'(act_log.size()), 32'd32);
    chk("short_last12", 32'(logb(12).last), 32'd0);
    chk("short_pad13", 32'(logb(13).data), 32'hAA);
    chk("short_last15", 32'(logb(15).last), 32'd1);
    chk("short_fix_lit", 32'(fix_act), 32'd1);

    // long line 2
    start_test();
    send_frame(8, 8, 11, 8);
    drain("long");
    chk("long_count", 32'(act_log.size()), 32'd32);
    chk("long_last23", 32'(logb(23).last), 32'd1);
    chk("long_fix_lit", 32'(fix_act), 32'd1);

    // early frame start after two lines
    start_test();
    send_frame(8, 8, 0, 0);
    send_clean();
    drain("early");
    chk("early_count", 32'(act_log.size()), 32'd64);
    chk("early_pad16", 32'(logb(16).data), 32'hAA);
    chk("early_pad31", 32'(logb(31).data), 32'hAA);
    chk("early_sof32", 32'(logb(32).user[0]), 32'd1);
    chk("early_fix_lit", 32'(fix_act), 32'd1);

    // random malformed frames, including a one-pixel-wide geometry
    for (int cfg = 0; cfg < 2; cfg++) begin
      param_width  = (cfg == 0) ? 10'd3 : 10'd1;
      param_height = (cfg == 0) ? 9'd2  : 9'd3;
      start_test();
      for (int f = 0; f < 6; f++) begin
        int nl;
        nl = int'(param_height) - 1 + int'($urandom_range(2));
        if (nl < 1) nl = 1;
        for (int l = 0; l < nl; l++)
          send_line(($urandom_range(3) == 0) ? 1 + int'($urandom_range(int'(param_width) + 1))
                                             : int'(param_width), (l == 0));
      end
      send_clean();
      drain($sformatf("rand%0d", cfg));
    end

    // source stall after pixel (3,1)
    param_width = 10'd8; param_height = 9'd4; param_timeout = 16'd50;
    start_test();
    send_line(8, 1'b1);
    for (int i = 0; i < 4; i++) send(TDW'($urandom), 2'b00, 1'b0);
    repeat (250) begin @(posedge aclk); #1; end
    m_timeout();
    drain("tmo");
    chk("tmo_busy", 32'(busy), 32'd0);
    send_clean();
    drain("tmo2");
    chk("tmo_count", 32'(act_log.size()), 32'd64);
    chk("tmo_pad12", 32'(logb(12).data), 32'hAA);
    chk("tmo_last15", 32'(logb(15).last), 32'd1);
    chk("tmo_fix_lit", 32'(fix_act), 32'd1);

    // reset mid-line with a stalled output
    param_timeout = '0;
    start_test();
    en_rand = 0; aclken = 1'b1; rdy_rand = 0; m_axi4s_tready = 1'b0; bubble = 0;
    send(8'h11, 2'b01, 1'b0);
    repeat (2) begin @(posedge aclk); #1; end
    chk("rstmid_pre_tvalid", 32'(m_axi4s_tvalid), 32'd1);
    s_axi4s_tdata = 8'h22; s_axi4s_tuser = 2'b00; s_axi4s_tlast = 1'b0; s_axi4s_tvalid = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("rstmid_tvalid", 32'(m_axi4s_tvalid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    exp_q.delete(); act_q.delete();
    m_st = 0; m_x = 0; m_y = 0;
    s_axi4s_tvalid = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    start_test();
    en_rand = 1; rdy_rand = 1; bubble = 20;
    for (int i = 0; i < 3; i++) send(TDW'($urandom), 2'b10, (i == 2));
    send_clean();
    drain("rstmid");
    chk("rstmid_count", 32'(act_log.size()), 32'd32);
    chk("rstmid_sof0", 32'(logb(0).user[0]), 32'd1);
    chk("rstmid_fix_lit", 32'(fix_act), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jelly2_axi4s_video_regularizer.md
Name: jelly2_axi4s_video_regularizer

Overview:
- AXI4-Stream video stage that sits directly upstream of jelly2_axi4s_img_simple.
- Accepts a raw camera/DMA stream whose frames may be malformed: short lines, long lines, missing lines, or a stalled source.
- Re-emits every frame as exactly param_width x param_height pixels, so the img-bus converter downstream never loses frame or line alignment.
- Corrections are made by padding with param_fill, by dropping excess beats, or after a timeout.

Parameters:
- TUSER_WIDTH, 1, tuser width; bit 0 is frame start.
- TDATA_WIDTH, 8, pixel data width.
- X_WIDTH, 10, width of the x counter and of param_width.
- Y_WIDTH, 9, width of the y counter and of param_height.
- TIMEOUT_WIDTH, 16, width of the stall timeout counter.

Ports:
- aresetn  in  1  asynchronous active-low reset.
- aclk  in  1  clock.
- aclken  in  1  clock enable; no state advances while it is 0.
- param_width  in  X_WIDTH  pixels per line, >=1; sampled at frame start.
- param_height  in  Y_WIDTH  lines per frame, >=1; sampled at frame start.
- param_fill  in  TDATA_WIDTH  padding pixel value.
- param_timeout  in  TIMEOUT_WIDTH  stall limit in aclken cycles; 0 disables the timeout.
- s_axi4s_tuser  in  TUSER_WIDTH  input user; bit 0 = frame start.
- s_axi4s_tlast  in  1  input end of line.
- s_axi4s_tdata  in  TDATA_WIDTH  input pixel.
- s_axi4s_tvalid  in  1  input valid.
- s_axi4s_tready  out  1  input ready.
- m_axi4s_tuser  out  TUSER_WIDTH  output user.
- m_axi4s_tlast  out  1  output end of line.
- m_axi4s_tdata  out  TDATA_WIDTH  output pixel.
- m_axi4s_tvalid  out  1  output valid.
- m_axi4s_tready  in  1  output ready.
- busy  out  1  high while a frame is in progress (state != SYNC).
- fix_pulse  out  1  one-cycle pulse on every correction event.

Behaviour:
- Reset (asynchronous, aresetn=0):
  - state=SYNC; x, y and the timeout counter cleared.
  - m_axi4s_tvalid=0, m_axi4s_tuser=0, m_axi4s_tlast=0, m_axi4s_tdata=0, busy=0, fix_pulse=0.
  - Reset mid-frame discards everything; after reset the block waits in SYNC for a new frame start.
- Output register:
  - Single output stage; it loads when aclken && (!m_axi4s_tvalid || m_axi4s_tready), called `adv`.
  - Latency is 1 aclken cycle from input accept to m_axi4s_tvalid.
  - Once m_axi4s_tvalid is high, the output payload stays stable until it is accepted.
- Output field rules, applied to every emitted beat:
  - tuser[0] = (x==0 && y==0).
  - tuser[TUSER_WIDTH-1:1] is passed from the input on passed beats and is 0 on padded beats.
  - tlast = (x==W-1).
  - x wraps to 0 after W-1; y increments on each x wrap.
- State SYNC:
  - s_axi4s_tready = aclken; every beat is dropped except one with tuser[0]=1.
  - On a tuser[0] beat: latch W=param_width and H=param_height, emit that beat as (0,0), x=1, go to PASS.
  - With W=1, that first beat itself ends the line, so the next state is chosen by the rules below.
- State PASS:
  - s_axi4s_tready = adv && !(s_axi4s_tuser[0] && !(x==0 && y==0)).
  - Each accepted beat is emitted as-is with the generated tuser/tlast.
  - Input tlast with x<W-1: fix_pulse, go PAD_LINE.
  - x==W-1 without input tlast: fix_pulse, go SKIP.
  - Last pixel of the frame (x==W-1, y==H-1): go SYNC; any excess input is dropped there.
  - Early frame start (s_axi4s_tuser[0]=1 with (x,y)!=(0,0)): the beat is not consumed; fix_pulse, go PAD_FRAME.
  - Timeout counter:
    - Increments on aclken cycles in PASS with no accept; clears on an accept.
    - When it equals param_timeout (param_timeout!=0): fix_pulse, go PAD_FRAME.
- State PAD_LINE:
  - s_axi4s_tready=0; emit param_fill on each adv until x==W-1.
  - Then go PASS, or go SYNC if y==H-1.
- State SKIP:
  - s_axi4s_tready=aclken; beats are dropped.
  - A tlast beat is dropped, then go PASS, or SYNC if the frame is complete.
  - A tuser[0] beat is not consumed: go PAD_FRAME (fix_pulse), or SYNC if the frame is complete.
- State PAD_FRAME:
  - s_axi4s_tready=0; emit param_fill through (W-1, H-1), then go SYNC.
  - The pending frame-start beat is then accepted by SYNC, which adds one bubble cycle.
- Simultaneous events:
  - Input tlast together with x==W-1 is a normal line end, not a correction.
  - Timeout and an input beat in the same cycle: the beat wins and the counter clears.
- Parameter changes mid-frame are ignored until the next SYNC latch.
- aclken=0: no state, counter or output register change; s_axi4s_tready=0.
- Widths:
  - Counter comparisons use X_WIDTH/Y_WIDTH unsigned.
  - param_width=0 and param_height=0 are illegal and unchecked.

Test Plan:
- W=8,H=4, clean 8x4 frames, random valid/ready at 20%/30% busy -> output identical to input, fix_pulse never high, one (0,0) tuser per frame.
- W=8,H=4, line 1 has only 5 pixels (tlast on the 5th) -> line 1 output is 5 passed pixels + 3 pixels of param_fill=0xAA with tlast on the 8th; one fix_pulse.
- W=8,H=4, line 2 has 11 pixels -> 8 passed with tlast on the 8th, 3 dropped; the next line aligns; one fix_pulse.
- W=8,H=4, new tuser[0] after 2 lines -> lines 2-3 fully padded with 0xAA, then the new frame is emitted correctly from (0,0).
- param_timeout=50, source stops after pixel (3,1) -> after 50 idle aclken cycles the remainder of the frame is padded; busy drops; a later frame is accepted.
- Assert aresetn low mid-line, with m_axi4s_tvalid=1 and stalled -> tvalid=0 immediately; beats without tuser[0] after release are dropped until the next frame start.
